// File: rtl/mem_wb_stage_if.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_if
//   Bundles the EX/MEM-side inputs, the pipeline control (stall/flush) and the
//   MEM/WB-side outputs of the memory-access stage.
//
//   master : pipeline control / upstream side (drives MEM_*, stall, flush)
//   slave  : the mem_wb_stage itself (drives WB_* and MEM_memErr)
//
//   MEM_PC        32  PC of instruction in MEM
//   MEM_aluResult 32  effective byte address / ALU result
//   MEM_storeData 32  forwarded rt value for stores
//   MEM_MemWrite   1  store enable
//   MEM_MemRead    1  load enable
//   MEM_memOp      3  access size / extension select
//   MEM_RegWrite   1  register write enable (passed through)
//   MEM_RegSrc     2  WB mux select (passed through)
//   MEM_rd         5  destination register (passed through)
//   stall          1  hold MEM/WB register, suppress store
//   flush          1  load bubble into MEM/WB, suppress store
//   WB_*              registered copies for the WB stage
//   MEM_memErr     1  combinational access-error flag
// -----------------------------------------------------------------------------
interface mem_wb_stage_if;
    logic [31:0] MEM_PC;
    logic [31:0] MEM_aluResult;
    logic [31:0] MEM_storeData;
    logic        MEM_MemWrite;
    logic        MEM_MemRead;
    logic [2:0]  MEM_memOp;
    logic        MEM_RegWrite;
    logic [1:0]  MEM_RegSrc;
    logic [4:0]  MEM_rd;
    logic        stall;
    logic        flush;

    logic [31:0] WB_PC;
    logic [31:0] WB_aluResult;
    logic [31:0] WB_memData;
    logic        WB_RegWrite;
    logic [1:0]  WB_RegSrc;
    logic [4:0]  WB_rd;
    logic        WB_memErr;
    logic        MEM_memErr;

    modport master (
        output MEM_PC, MEM_aluResult, MEM_storeData, MEM_MemWrite, MEM_MemRead,
               MEM_memOp, MEM_RegWrite, MEM_RegSrc, MEM_rd, stall, flush,
        input  WB_PC, WB_aluResult, WB_memData, WB_RegWrite, WB_RegSrc, WB_rd,
               WB_memErr, MEM_memErr
    );

    modport slave (
        input  MEM_PC, MEM_aluResult, MEM_storeData, MEM_MemWrite, MEM_MemRead,
               MEM_memOp, MEM_RegWrite, MEM_RegSrc, MEM_rd, stall, flush,
        output WB_PC, WB_aluResult, WB_memData, WB_RegWrite, WB_RegSrc, WB_rd,
               WB_memErr, MEM_memErr
    );
endinterface

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory-access stage plus the MEM/WB pipeline register.
//   Owns a little-endian, byte-addressed data memory (dataMem) based at 0.
//   Stores (sw/sh/sb) write on the rising edge with per-byte lane enables;
//   loads (lw/lh/lhu/lb/lbu) read combinationally, are sign/zero extended and
//   registered into WB_memData (one cycle MEM->WB).
//
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset (clears WB_*, not memory)
//   bus  : mem_wb_stage_if.slave, see interface header for signal list
//
//   memOp encoding: 000 word, 001 half signed, 010 half unsigned,
//                   011 byte signed, 100 byte unsigned, 101..111 illegal
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 10
) (
    input  logic            clk,
    input  logic            rst,
    mem_wb_stage_if.slave   bus
);

    localparam logic [2:0] OP_WORD  = 3'b000;
    localparam logic [2:0] OP_HALF  = 3'b001;
    localparam logic [2:0] OP_HALFU = 3'b010;
    localparam logic [2:0] OP_BYTE  = 3'b011;
    localparam logic [2:0] OP_BYTEU = 3'b100;

    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0] dataMem [DEPTH_WORDS];

    logic [31:0]          addr;
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    logic                 access;
    logic                 misaligned;
    logic                 out_of_range;
    logic                 op_illegal;
    logic                 mem_err;

    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] extracted;
    logic [31:0] load_data;

    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic        wr_en;

    assign addr     = bus.MEM_aluResult;
    assign word_idx = addr[ADDR_BITS+1:2];
    assign lane     = addr[1:0];
    assign access   = bus.MEM_MemRead | bus.MEM_MemWrite;

    // ------------------------------------------------------------------
    // Error detection
    // ------------------------------------------------------------------
    always_comb begin
        misaligned = 1'b0;
        case (bus.MEM_memOp)
            OP_WORD:           misaligned = (lane != 2'b00);
            OP_HALF, OP_HALFU: misaligned = lane[0];
            default:           misaligned = 1'b0;
        endcase
    end

    assign out_of_range = (addr >= MEM_BYTES);
    assign op_illegal   = (bus.MEM_memOp > OP_BYTEU);

    // A simultaneous read and write has no defined meaning here, so it is
    // reported as an error and neither side takes effect.
    assign mem_err = access & (misaligned | out_of_range | op_illegal |
                               (bus.MEM_MemRead & bus.MEM_MemWrite));

    assign bus.MEM_memErr = mem_err;

    // ------------------------------------------------------------------
    // Load path: combinational read, lane select, extension
    // ------------------------------------------------------------------
    // Out-of-range addresses alias onto a valid index here; the error flag
    // zeroes the result so the aliased value never reaches WB.
    assign rd_word = dataMem[word_idx];

    always_comb begin
        rd_byte = 8'h00;
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        extracted = 32'h0;
        case (bus.MEM_memOp)
            OP_WORD:  extracted = rd_word;
            OP_HALF:  extracted = {{16{rd_half[15]}}, rd_half};
            OP_HALFU: extracted = {16'h0, rd_half};
            OP_BYTE:  extracted = {{24{rd_byte[7]}}, rd_byte};
            OP_BYTEU: extracted = {24'h0, rd_byte};
            default:  extracted = 32'h0;
        endcase
    end

    assign load_data = mem_err ? 32'h0 : extracted;

    // ------------------------------------------------------------------
    // Store path: lane enables and replicated write data
    // ------------------------------------------------------------------
    always_comb begin
        byte_en = 4'b0000;
        wr_data = bus.MEM_storeData;
        case (bus.MEM_memOp)
            OP_WORD: begin
                byte_en = 4'b1111;
                wr_data = bus.MEM_storeData;
            end
            OP_HALF, OP_HALFU: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.MEM_storeData[15:0]}};
            end
            OP_BYTE, OP_BYTEU: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{bus.MEM_storeData[7:0]}};
            end
            default: begin
                byte_en = 4'b0000;
                wr_data = bus.MEM_storeData;
            end
        endcase
    end

    // A stalled or flushed instruction will be replayed or discarded, so its
    // store must not land; a store coinciding with reset is dropped as well.
    assign wr_en = bus.MEM_MemWrite & ~mem_err & ~bus.stall & ~bus.flush & ~rst;

    // Memory contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    dataMem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB pipeline register (priority: rst > flush > stall > normal)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.WB_PC        <= 32'h0;
            bus.WB_aluResult <= 32'h0;
            bus.WB_memData   <= 32'h0;
            bus.WB_RegWrite  <= 1'b0;
            bus.WB_RegSrc    <= 2'b00;
            bus.WB_rd        <= 5'd0;
            bus.WB_memErr    <= 1'b0;
        end else if (bus.flush) begin
            // Bubble: nothing in WB may have an architectural effect.
            bus.WB_PC        <= 32'h0;
            bus.WB_aluResult <= 32'h0;
            bus.WB_memData   <= 32'h0;
            bus.WB_RegWrite  <= 1'b0;
            bus.WB_RegSrc    <= 2'b00;
            bus.WB_rd        <= 5'd0;
            bus.WB_memErr    <= 1'b0;
        end else if (!bus.stall) begin
            bus.WB_PC        <= bus.MEM_PC;
            bus.WB_aluResult <= bus.MEM_aluResult;
            bus.WB_memData   <= load_data;
            bus.WB_RegWrite  <= bus.MEM_RegWrite & ~mem_err;
            bus.WB_RegSrc    <= bus.MEM_RegSrc;
            bus.WB_rd        <= bus.MEM_rd;
            bus.WB_memErr    <= mem_err;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int DEPTH_WORDS = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_BITS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] data;
        logic        rw;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic        err;
        bit          pc_known;
        bit          data_known;
    } wb_t;

    wb_t   model;
    wb_t   exp_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;
    logic [31:0] pc_ctr = 32'h0000_0100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        model.pc = 0; model.alu = 0; model.data = 0; model.rw = 0;
        model.src = 0; model.rd = 0; model.err = 0;
        model.pc_known = 1; model.data_known = 1;
    endtask

    // One instruction in MEM for one cycle. Expected WB contents are pushed
    // when driven and popped after the edge.
    task automatic step(input string tag, input logic rd_en, input logic wr_en,
                        input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic st, input logic fl,
                        input logic exp_err, input logic [31:0] exp_data,
                        input bit data_known);
        wb_t e;
        string t;
        pc_ctr = pc_ctr + 32'd4;
        bus.MEM_PC        = pc_ctr;
        bus.MEM_aluResult = addr;
        bus.MEM_storeData = sd;
        bus.MEM_MemRead   = rd_en;
        bus.MEM_MemWrite  = wr_en;
        bus.MEM_memOp     = op;
        bus.MEM_RegWrite  = rd_en;
        bus.MEM_RegSrc    = rd_en ? 2'b01 : 2'b10;
        bus.MEM_rd        = pc_ctr[6:2];
        bus.stall         = st;
        bus.flush         = fl;
        #1;
        chk({tag, " MEM_memErr"}, 32'(bus.MEM_memErr), 32'(exp_err));
        if (fl) begin
            model.rw = 0; model.src = 0; model.rd = 0; model.err = 0;
            model.pc_known = 0; model.data_known = 0;
        end else if (!st) begin
            model.pc = pc_ctr; model.alu = addr;
            model.data = exp_err ? 32'h0 : exp_data;
            model.data_known = data_known | exp_err;
            model.pc_known = 1;
            model.rw = rd_en & ~exp_err;
            model.src = rd_en ? 2'b01 : 2'b10;
            model.rd = pc_ctr[6:2];
            model.err = exp_err;
        end
        exp_q.push_back(model);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (e.pc_known) begin
            chk({t, " WB_PC"}, bus.WB_PC, e.pc);
            chk({t, " WB_aluResult"}, bus.WB_aluResult, e.alu);
        end
        if (e.data_known) chk({t, " WB_memData"}, bus.WB_memData, e.data);
        chk({t, " WB_RegWrite"}, 32'(bus.WB_RegWrite), 32'(e.rw));
        chk({t, " WB_RegSrc"}, 32'(bus.WB_RegSrc), 32'(e.src));
        chk({t, " WB_rd"}, 32'(bus.WB_rd), 32'(e.rd));
        chk({t, " WB_memErr"}, 32'(bus.WB_memErr), 32'(e.err));
    endtask

    task automatic check_wb_zero(input string tag);
        chk({tag, " WB_PC"}, bus.WB_PC, 32'h0);
        chk({tag, " WB_aluResult"}, bus.WB_aluResult, 32'h0);
        chk({tag, " WB_memData"}, bus.WB_memData, 32'h0);
        chk({tag, " WB_RegWrite"}, 32'(bus.WB_RegWrite), 32'h0);
        chk({tag, " WB_RegSrc"}, 32'(bus.WB_RegSrc), 32'h0);
        chk({tag, " WB_rd"}, 32'(bus.WB_rd), 32'h0);
        chk({tag, " WB_memErr"}, 32'(bus.WB_memErr), 32'h0);
    endtask

    initial begin
        bus.MEM_PC = 0; bus.MEM_aluResult = 0; bus.MEM_storeData = 0;
        bus.MEM_MemRead = 0; bus.MEM_MemWrite = 0; bus.MEM_memOp = 0;
        bus.MEM_RegWrite = 0; bus.MEM_RegSrc = 0; bus.MEM_rd = 0;
        bus.stall = 0; bus.flush = 0;
        model_clear();

        #12;
        check_wb_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Word store then mixed-width loads
        step("sw w0",  0, 1, 3'b000, 32'h0, 32'h1234_5678, 0, 0, 0, 32'h0, 0);
        step("lw 0",   1, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 32'h1234_5678, 1);
        step("lb 1",   1, 0, 3'b011, 32'h1, 32'h0, 0, 0, 0, 32'h0000_0056, 1);
        step("lbu 3",  1, 0, 3'b100, 32'h3, 32'h0, 0, 0, 0, 32'h0000_0012, 1);
        step("lh 2",   1, 0, 3'b001, 32'h2, 32'h0, 0, 0, 0, 32'h0000_1234, 1);

        // Byte store into an all-ones word
        step("sw w1",  0, 1, 3'b000, 32'h4, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 0);
        step("sb 5",   0, 1, 3'b011, 32'h5, 32'hABCD_EF80, 0, 0, 0, 32'h0, 0);
        step("lb 5",   1, 0, 3'b011, 32'h5, 32'h0, 0, 0, 0, 32'hFFFF_FF80, 1);
        step("lbu 5",  1, 0, 3'b100, 32'h5, 32'h0, 0, 0, 0, 32'h0000_0080, 1);
        step("lw 4",   1, 0, 3'b000, 32'h4, 32'h0, 0, 0, 0, 32'hFFFF_80FF, 1);

        // Half store into upper lane of a zero word
        step("sw w2",  0, 1, 3'b000, 32'h8, 32'h0, 0, 0, 0, 32'h0, 0);
        step("sh A",   0, 1, 3'b001, 32'hA, 32'h1234_BEEF, 0, 0, 0, 32'h0, 0);
        chk("dataMem[2]", dut.dataMem[2], 32'hBEEF_0000);
        step("lh A",   1, 0, 3'b001, 32'hA, 32'h0, 0, 0, 0, 32'hFFFF_BEEF, 1);
        step("lhu A",  1, 0, 3'b010, 32'hA, 32'h0, 0, 0, 0, 32'h0000_BEEF, 1);

        // Error cases: misaligned, out of range, illegal op, read+write
        step("sw 2 err",   0, 1, 3'b000, 32'h2, 32'hDEAD_BEEF, 0, 0, 1, 32'h0, 1);
        step("lh 3 err",   1, 0, 3'b001, 32'h3, 32'h0, 0, 0, 1, 32'h0, 1);
        step("lw oor err", 1, 0, 3'b000, 32'(DEPTH_WORDS*4), 32'h0, 0, 0, 1, 32'h0, 1);
        step("op101 err",  1, 0, 3'b101, 32'h0, 32'h0, 0, 0, 1, 32'h0, 1);
        step("rdwr err",   1, 1, 3'b000, 32'h4, 32'h5555_5555, 0, 0, 1, 32'h0, 1);
        step("sw last",    0, 1, 3'b000, 32'(DEPTH_WORDS*4-4), 32'hCAFE_F00D, 0, 0, 0, 32'h0, 0);
        step("lw last",    1, 0, 3'b000, 32'(DEPTH_WORDS*4-4), 32'h0, 0, 0, 0, 32'hCAFE_F00D, 1);
        step("lw 0 after", 1, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 32'h1234_5678, 1);
        step("lw 4 after", 1, 0, 3'b000, 32'h4, 32'h0, 0, 0, 0, 32'hFFFF_80FF, 1);

        // Reset mid-operation with WB_RegWrite=1 and a store pending
        bus.MEM_aluResult = 32'h0; bus.MEM_storeData = 32'hDEAD_BEEF;
        bus.MEM_MemWrite = 1; bus.MEM_MemRead = 0; bus.MEM_memOp = 3'b000;
        bus.MEM_RegWrite = 0;
        rst = 1'b1;
        #1;
        check_wb_zero("mid reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk("dataMem[0] after rst", dut.dataMem[0], 32'h1234_5678);
        step("lw 0 post rst", 1, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 32'h1234_5678, 1);

        // Stall then flush suppress the store; then a normal store
        step("sw 10 init",  0, 1, 3'b000, 32'h10, 32'h0, 0, 0, 0, 32'h0, 0);
        step("lw 0 pre",    1, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 32'h1234_5678, 1);
        step("sw 10 stall", 0, 1, 3'b000, 32'h10, 32'hAAAA_5555, 1, 0, 0, 32'h0, 0);
        step("sw 10 flush", 0, 1, 3'b000, 32'h10, 32'hAAAA_5555, 0, 1, 0, 32'h0, 0);
        chk("dataMem[4] held", dut.dataMem[4], 32'h0);
        step("lw 10 old",   1, 0, 3'b000, 32'h10, 32'h0, 0, 0, 0, 32'h0, 1);
        step("sw 10",       0, 1, 3'b000, 32'h10, 32'hAAAA_5555, 0, 0, 0, 32'h0, 0);
        chk("dataMem[4] new", dut.dataMem[4], 32'hAAAA_5555);
        step("lw 10 new",   1, 0, 3'b000, 32'h10, 32'h0, 0, 0, 0, 32'hAAAA_5555, 1);

        bus.MEM_MemRead = 0; bus.MEM_MemWrite = 0;
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
